pdm_audio_sequencer: RTL and testbench

Sequencer for a stereo PDM link. It generates the PDM bit clock `ock` from `clk` and feeds stereo playback samples to the stereo modulator through a valid/ready input. It also decimates the stereo demodulator outputs into a valid/ready capture stream. A start/warm-up/run/stop state machine governs both directions, and sticky flags report underrun and overrun.

---
 rtl/pdm_audio_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_pdm_audio_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_audio_sequencer.sv
// Stereo PDM link sequencer: ock generation, playback hold register, decimated capture.
// Optional macro PDM_AUDIO_SEQ_MUTE_EN adds a `mute` input that forces midscale RUN loads.
module pdm_audio_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [7:0]   div,
    input  logic [7:0]   decim,
    input  logic [7:0]   warm,
`ifdef PDM_AUDIO_SEQ_MUTE_EN
    input  logic         mute,
`endif
    output logic         ock,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_l,
    input  logic [W-1:0] in_r,
    output logic [W-1:0] mod_din_l,
    output logic [W-1:0] mod_din_r,
    input  logic [W-1:0] dem_l,
    input  logic [W-1:0] dem_r,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_l,
    output logic [W-1:0] out_r,
    output logic         busy,
    output logic         underrun,
    output logic         overrun
);
    typedef enum logic [1:0] {IDLE, WARM, RUN, STOP} state_e;
    localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

    state_e       state_q, state_d;
    logic         ock_q, ock_d;
    logic [7:0]   cnt_q, cnt_d, ediv_q, ediv_d, decim_q, decim_d, warm_q, warm_d;
    logic [7:0]   wcnt_q, wcnt_d, dcnt_q, dcnt_d;
    logic         hold_full_q, hold_full_d, out_valid_q, out_valid_d;
    logic         und_q, und_d, ovr_q, ovr_d;
    logic [W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [W-1:0] mod_l_q, mod_l_d, mod_r_q, mod_r_d;
    logic [W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic         mute_w, running, rise, run_rise, xfer;
    logic [7:0]   div_eff, decim_eff;

`ifdef PDM_AUDIO_SEQ_MUTE_EN
    assign mute_w = mute;
`else
    assign mute_w = 1'b0;
`endif

    assign div_eff   = (div < 8'd2) ? 8'd2 : div;
    assign decim_eff = (decim == 8'd0) ? 8'd1 : decim;
    assign running   = (state_q == WARM) || (state_q == RUN);
    assign rise      = running && !ock_q && (cnt_q == 8'd0);
    assign run_rise  = rise && (state_q == RUN);
    assign in_ready  = (state_q == RUN) && !hold_full_q;
    assign xfer      = in_valid && in_ready;

    assign ock       = ock_q;
    assign mod_din_l = mod_l_q;
    assign mod_din_r = mod_r_q;
    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign busy      = (state_q != IDLE);
    assign underrun  = und_q;
    assign overrun   = ovr_q;

    always_comb begin
        state_d     = state_q;
        ock_d       = ock_q;
        cnt_d       = cnt_q;
        ediv_d      = ediv_q;
        decim_d     = decim_q;
        warm_d      = warm_q;
        wcnt_d      = wcnt_q;
        dcnt_d      = dcnt_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        mod_l_d     = mod_l_q;
        mod_r_d     = mod_r_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q;
        und_d       = und_q;
        ovr_d       = ovr_q;

        // Phase counter keeps running in STOP so a high phase can finish; it never rises there.
        if (state_q != IDLE) begin
            if (cnt_q == 8'd0) begin
                cnt_d = ediv_q;
                if (running || ock_q) ock_d = !ock_q;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end

        if (run_rise) begin
            if (hold_full_q) begin
                mod_l_d     = mute_w ? MID : hold_l_q;
                mod_r_d     = mute_w ? MID : hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                und_d = 1'b1;
            end
        end
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_l_d    = in_l;
            hold_r_d    = in_r;
        end

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (run_rise) begin
            if (dcnt_q + 8'd1 == decim_q) begin
                dcnt_d = 8'd0;
                if (out_valid_q && !out_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    out_l_d     = dem_l;
                    out_r_d     = dem_r;
                    out_valid_d = 1'b1;
                end
            end else begin
                dcnt_d = dcnt_q + 8'd1;
            end
        end

        case (state_q)
            IDLE: if (en) begin
                ediv_d      = div_eff;
                decim_d     = decim_eff;
                warm_d      = warm;
                cnt_d       = div_eff;
                ock_d       = 1'b0;
                wcnt_d      = 8'd0;
                dcnt_d      = 8'd0;
                hold_full_d = 1'b0;
                und_d       = 1'b0;
                ovr_d       = 1'b0;
                state_d     = (warm != 8'd0) ? WARM : RUN;
            end
            WARM: begin
                if (rise) begin
                    if (wcnt_q + 8'd1 == warm_q) begin
                        wcnt_d  = 8'd0;
                        state_d = RUN;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
                if (!en) state_d = STOP;
            end
            RUN: if (!en) state_d = STOP;
            STOP: if (!ock_q) begin
                state_d     = IDLE;
                hold_full_d = 1'b0;
                mod_l_d     = MID;
                mod_r_d     = MID;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ock_q       <= 1'b0;
            cnt_q       <= 8'd0;
            ediv_q      <= 8'd2;
            decim_q     <= 8'd1;
            warm_q      <= 8'd0;
            wcnt_q      <= 8'd0;
            dcnt_q      <= 8'd0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            mod_l_q     <= MID;
            mod_r_q     <= MID;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            und_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ock_q       <= ock_d;
            cnt_q       <= cnt_d;
            ediv_q      <= ediv_d;
            decim_q     <= decim_d;
            warm_q      <= warm_d;
            wcnt_q      <= wcnt_d;
            dcnt_q      <= dcnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            mod_l_q     <= mod_l_d;
            mod_r_q     <= mod_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            und_q       <= und_d;
            ovr_q       <= ovr_d;
        end
    end
endmodule

// File: tb/tb_pdm_audio_sequencer.sv
// Bench for pdm_audio_sequencer: scenario tasks plus a playback/capture scoreboard monitor.
module tb_pdm_audio_sequencer;
    localparam int W = 32;
    localparam logic [31:0] MID = 32'h8000_0000;
    localparam logic [31:0] AL  = 32'h4000_0000;
    localparam logic [31:0] AR  = 32'hC000_0000;

    logic clk = 1'b0, rstn = 1'b0, en = 1'b0;
    logic [7:0] div = 8'd2, decim = 8'd1, warm = 8'd2;
    logic ock, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [W-1:0] in_l = '0, in_r = '0, mod_din_l, mod_din_r, dem_l = '0, dem_r = '0, out_l, out_r;
    logic busy, underrun, overrun;

    pdm_audio_sequencer #(.W(W)) dut (
        .clk(clk), .rstn(rstn), .en(en), .div(div), .decim(decim), .warm(warm),
        .ock(ock), .in_valid(in_valid), .in_ready(in_ready), .in_l(in_l), .in_r(in_r),
        .mod_din_l(mod_din_l), .mod_din_r(mod_din_r), .dem_l(dem_l), .dem_r(dem_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
        .busy(busy), .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] l; logic [31:0] r;} pair_t;
    pair_t pq[$];
    pair_t cq[$];
    int n_chk = 0, n_fail = 0;
    bit mon_en = 0, rnd_in = 0;
    int rise_cnt = 0, dcnt = 0, m_warm = 0, m_decim = 1;
    logic exp_und = 1'b0, exp_ovr = 1'b0;
    logic p_ock, p_iv, p_ir, p_ov, p_or;
    logic [31:0] p_il, p_irr, p_ol, p_orr, p_dl, p_dr, p_ml, p_mr;

    // Fresh demodulator data every cycle; optional random playback data.
    initial forever begin
        @(posedge clk); #1;
        dem_l = $urandom; dem_r = $urandom;
        if (rnd_in) begin in_l = $urandom; in_r = $urandom; end
    end

    task automatic mon_start(input int w, input int d);
        pq.delete();
        rise_cnt = 0; dcnt = 0; m_warm = w; m_decim = (d == 0) ? 1 : d;
        exp_und = 1'b0; exp_ovr = 1'b0; mon_en = 1;
    endtask

    // Scoreboard: pairs pushed on handshakes/captures, popped on RUN rises/capture handshakes.
    initial forever begin
        @(negedge clk);
        p_ock = ock; p_iv = in_valid; p_ir = in_ready; p_ov = out_valid; p_or = out_ready;
        p_il = in_l; p_irr = in_r; p_ol = out_l; p_orr = out_r; p_dl = dem_l; p_dr = dem_r;
        p_ml = mod_din_l; p_mr = mod_din_r;
        @(posedge clk); #1;
        if (mon_en) begin
            pair_t e;
            if (p_ov && p_or) begin
                n_chk++;
                if (cq.size() == 0) begin
                    n_fail++; $display("FAIL cap_pop: out handshake with no expected capture");
                end else begin
                    e = cq.pop_front();
                    if ({p_ol, p_orr} !== {e.l, e.r}) begin
                        n_fail++; $display("FAIL cap_data: got %h/%h expected %h/%h", p_ol, p_orr, e.l, e.r);
                    end
                end
            end
            if (!p_ock && ock) begin
                rise_cnt++;
                if (rise_cnt > m_warm) begin
                    if (pq.size() != 0) e = pq.pop_front();
                    else begin exp_und = 1'b1; e = {p_ml, p_mr}; end
                    n_chk++;
                    if ({mod_din_l, mod_din_r} !== {e.l, e.r}) begin
                        n_fail++; $display("FAIL mod_load: got %h/%h expected %h/%h", mod_din_l, mod_din_r, e.l, e.r);
                    end
                    dcnt++;
                    if (dcnt == m_decim) begin
                        dcnt = 0;
                        if (p_ov && !p_or) begin
                            exp_ovr = 1'b1; n_chk++;
                            if ({out_l, out_r} !== {p_ol, p_orr}) begin
                                n_fail++; $display("FAIL cap_keep: got %h/%h expected %h/%h", out_l, out_r, p_ol, p_orr);
                            end
                        end else cq.push_back({p_dl, p_dr});
                    end
                end else begin
                    n_chk++;
                    if ({mod_din_l, mod_din_r} !== {MID, MID}) begin
                        n_fail++; $display("FAIL mod_warm: got %h/%h expected %h", mod_din_l, mod_din_r, MID);
                    end
                end
                n_chk++;
                if ({underrun, overrun} !== {exp_und, exp_ovr}) begin
                    n_fail++; $display("FAIL flags: got und=%b ovr=%b expected und=%b ovr=%b", underrun, overrun, exp_und, exp_ovr);
                end
            end else if (busy) begin
                n_chk++;
                if ({mod_din_l, mod_din_r} !== {p_ml, p_mr}) begin
                    n_fail++; $display("FAIL mod_stable: got %h/%h expected %h/%h", mod_din_l, mod_din_r, p_ml, p_mr);
                end
            end
            if (p_iv && p_ir) pq.push_back({p_il, p_irr});
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        en = 1'b0;
        while (busy && n < 200) begin tick(); n++; end
        ok = !busy;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        n_chk++;
        if ({ock, in_ready, out_valid, busy, underrun, overrun} !== 6'b0 ||
            {mod_din_l, mod_din_r} !== {MID, MID} || {out_l, out_r} !== 64'd0) begin
            n_fail++; $display("FAIL reset_vals: ock=%b rdy=%b ov=%b busy=%b mod=%h/%h out=%h/%h",
                               ock, in_ready, out_valid, busy, mod_din_l, mod_din_r, out_l, out_r);
        end
        rstn = 1'b1;
        tick();
        n_chk++;
        if (busy !== 1'b0 || ock !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: busy=%b ock=%b expected 0/0", busy, ock);
        end
    endtask

    task automatic test_basic(input string tag);
        int t = 0, r = 0, t1 = 0, t2 = 0;
        logic pv;
        div = 8'd2; warm = 8'd2; decim = 8'd1; out_ready = 1'b1;
        rnd_in = 0; in_l = AL; in_r = AR; in_valid = 1'b1;
        mon_start(2, 1);
        en = 1'b1;
        while (r < 10 && t < 200) begin
            pv = ock; tick(); t++;
            if (!pv && ock) begin
                r++;
                if (r == 1) t1 = t;
                if (r == 2) t2 = t;
                if (r <= 2) begin
                    n_chk++;
                    if (mod_din_l !== MID || mod_din_r !== MID) begin
                        n_fail++; $display("FAIL %s_warm_mid: rise %0d mod=%h/%h expected %h", tag, r, mod_din_l, mod_din_r, MID);
                    end
                end
                if (r == 3) begin
                    n_chk++;
                    if (mod_din_l !== AL || mod_din_r !== AR || out_valid !== 1'b1) begin
                        n_fail++; $display("FAIL %s_first_load: mod=%h/%h ov=%b expected %h/%h ov=1", tag, mod_din_l, mod_din_r, out_valid, AL, AR);
                    end
                end
            end
        end
        n_chk++;
        if (r != 10) begin n_fail++; $display("FAIL %s_timeout: %0d rises expected 10", tag, r); end
        n_chk++;
        if (t1 != 4) begin n_fail++; $display("FAIL %s_first_rise: cycle %0d expected 4", tag, t1); end
        n_chk++;
        if (t2 - t1 != 6) begin n_fail++; $display("FAIL %s_period: %0d expected 6", tag, t2 - t1); end
        n_chk++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL %s_no_underrun: got %b expected 0", tag, underrun); end
    endtask

    task automatic test_div0();
        int t = 0, r = 0, t1 = 0, t2 = 0, bad = 0;
        logic pv;
        bit ok;
        wait_idle(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL div0_stop: busy stuck at %b expected 0", busy); end
        div = 8'd0; warm = 8'd0; decim = 8'd0; rnd_in = 1; in_valid = 1'b1; out_ready = 1'b1;
        mon_start(0, 0);
        en = 1'b1;
        while (r < 6 && t < 200) begin
            pv = ock; tick(); t++;
            if (!pv && ock) begin
                r++;
                if (r == 1) t1 = t;
                if (r == 2) t2 = t;
                if (out_valid !== 1'b1) bad++;
            end
        end
        n_chk++;
        if (t1 != 4 || t2 - t1 != 6) begin
            n_fail++; $display("FAIL div0_period: first=%0d period=%0d expected 4/6", t1, t2 - t1);
        end
        n_chk++;
        if (r != 6 || bad != 0) begin
            n_fail++; $display("FAIL decim0_capture: rises=%0d missing=%0d expected 6/0", r, bad);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] ml, mr;
        bit ok;
        ml = mod_din_l; mr = mod_din_r;
        in_valid = 1'b0;
        repeat (14) tick();
        n_chk++;
        if (mod_din_l !== ml || mod_din_r !== mr || underrun !== 1'b1) begin
            n_fail++; $display("FAIL underrun_hold: mod=%h/%h und=%b expected %h/%h und=1", mod_din_l, mod_din_r, underrun, ml, mr);
        end
        in_valid = 1'b1;
        repeat (14) tick();
        n_chk++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
        wait_idle(ok);
        n_chk++;
        if (underrun !== 1'b1 || !ok) begin n_fail++; $display("FAIL underrun_idle: und=%b ok=%b expected 1/1", underrun, ok); end
        mon_start(0, 0);
        en = 1'b1;
        tick();
        n_chk++;
        if (underrun !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL underrun_clear: und=%b busy=%b expected 0/1", underrun, busy);
        end
    endtask

    task automatic test_overrun();
        int t = 0, r = 0;
        logic pv;
        logic [31:0] ol = '0, orr = '0;
        bit ok;
        out_ready = 1'b1;
        wait_idle(ok);
        div = 8'd2; warm = 8'd0; decim = 8'd4;
        mon_start(0, 4);
        en = 1'b1;
        tick();
        out_ready = 1'b0;
        while (r < 8 && t < 300) begin
            pv = ock; tick(); t++;
            if (!pv && ock) begin
                r++;
                if (r == 3) begin
                    n_chk++;
                    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_early: out_valid=%b expected 0 at rise 3", out_valid); end
                end
                if (r == 4) begin
                    ol = out_l; orr = out_r;
                    n_chk++;
                    if (out_valid !== 1'b1 || overrun !== 1'b0) begin
                        n_fail++; $display("FAIL ovr_first_cap: ov=%b ovr=%b expected 1/0", out_valid, overrun);
                    end
                end
                if (r == 8) begin
                    n_chk++;
                    if (overrun !== 1'b1 || out_l !== ol || out_r !== orr) begin
                        n_fail++; $display("FAIL ovr_set: ovr=%b out=%h/%h expected 1 %h/%h", overrun, out_l, out_r, ol, orr);
                    end
                end
            end
        end
        n_chk++;
        if (r != 8) begin n_fail++; $display("FAIL ovr_timeout: %0d rises expected 8", r); end
        out_ready = 1'b1;
        tick();
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_stop();
        int n = 0, hi1 = 0, low_bad = 0;
        logic pv = 1'b1;
        while (!(!pv && ock) && n < 100) begin pv = ock; tick(); n++; end
        en = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick(); n++;
            if (n == 1) hi1 = ock;
        end
        n_chk++;
        if (n != 4 || hi1 != 1) begin
            n_fail++; $display("FAIL stop_timing: idle after %0d cycles ock_hi=%0d expected 4/1", n, hi1);
        end
        n_chk++;
        if (mod_din_l !== MID || mod_din_r !== MID || ock !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_idle: mod=%h/%h ock=%b busy=%b expected %h 0 0", mod_din_l, mod_din_r, ock, busy, MID);
        end
        repeat (10) begin tick(); if (ock !== 1'b0) low_bad++; end
        n_chk++;
        if (low_bad != 0) begin n_fail++; $display("FAIL stop_ock_low: %0d high cycles expected 0", low_bad); end
    endtask

    task automatic test_reset_mid();
        int r = 0, n = 0;
        logic pv;
        div = 8'd2; warm = 8'd2; decim = 8'd1; out_ready = 1'b1;
        rnd_in = 0; in_l = AL; in_r = AR; in_valid = 1'b1;
        mon_start(2, 1);
        en = 1'b1;
        while (r < 5 && n < 200) begin pv = ock; tick(); n++; if (!pv && ock) r++; end
        #3;
        mon_en = 0;
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({ock, in_ready, out_valid, busy, underrun, overrun} !== 6'b0 ||
            {mod_din_l, mod_din_r} !== {MID, MID} || {out_l, out_r} !== 64'd0 || r != 5) begin
            n_fail++; $display("FAIL reset_async: ock=%b rdy=%b ov=%b busy=%b mod=%h/%h out=%h/%h rises=%0d",
                               ock, in_ready, out_valid, busy, mod_din_l, mod_din_r, out_l, out_r, r);
        end
        pq.delete(); cq.delete();
        tick();
        rstn = 1'b1;
        test_basic("restart");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_div0();
        test_underrun();
        test_overrun();
        test_stop();
        test_reset_mid();
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
